// File: rtl/fetch_ctrl_if.sv
// Handshake bundle for the frame fetch controller: frame control, fetch
// datapath read port, and the chunk stream towards the downstream BNN layer.
interface fetch_ctrl_if #(
   parameter int W  = 16,
   parameter int NW = 5,
   parameter int NC = 4
);
   localparam int IW = (NC > 1) ? $clog2(NC) : 1;

   logic              frame_valid;
   logic              frame_ack;
   logic              fetch_empty;
   logic              fetch_rd_en;
   logic [NW*W-1:0]   chunk_in;
   logic [NW*W-1:0]   chunk_out;
   logic              chunk_valid;
   logic              chunk_ready;
   logic [IW-1:0]     chunk_idx;
   logic              chunk_last;
   logic              busy;
   logic              err;

   modport master (
      input  frame_valid, fetch_empty, chunk_in, chunk_ready,
      output frame_ack, fetch_rd_en, chunk_out, chunk_valid,
             chunk_idx, chunk_last, busy, err
   );

   modport slave (
      output frame_valid, fetch_empty, chunk_in, chunk_ready,
      input  frame_ack, fetch_rd_en, chunk_out, chunk_valid,
             chunk_idx, chunk_last, busy, err
   );
endinterface

// File: rtl/fetch_ctrl.sv
// Frame fetch controller: reads a frame chunk by chunk from the fetch datapath
// and presents each chunk downstream with a valid/ready handshake.
//
// state | meaning
// IDLE  | waiting for frame_valid
// REQ   | read strobe to fetch datapath (or drop frame on empty)
// CAPT  | register the fetched chunk
// HOLD  | chunk_out valid, waiting for chunk_ready
// DONE  | one-cycle frame_ack, chunk index rewinds
module fetch_ctrl #(
   parameter int W  = 16,
   parameter int NW = 5,
   parameter int NC = 4
) (
   input  logic          clk,
   input  logic          rst,
   fetch_ctrl_if.master  bus
);
   localparam int IW = (NC > 1) ? $clog2(NC) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(NC - 1);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_REQ  = 3'd1,
      S_CAPT = 3'd2,
      S_HOLD = 3'd3,
      S_DONE = 3'd4
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic [NW*W-1:0]   r_chunk_out;
   logic [IW-1:0]     r_idx;
   logic              r_err;
   logic              w_handshake;

   assign w_handshake = (r_state == S_HOLD) && bus.chunk_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: if (bus.frame_valid) w_next = S_REQ;
         S_REQ:  w_next = bus.fetch_empty ? S_DONE : S_CAPT;
         S_CAPT: w_next = S_HOLD;
         S_HOLD: if (w_handshake) w_next = (r_idx == LAST_IDX) ? S_DONE : S_REQ;
         S_DONE: w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Datapath registers: chunk capture, chunk index, sticky underrun flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_chunk_out <= '0;
         r_idx       <= '0;
         r_err       <= 1'b0;
      end else begin
         if (r_state == S_CAPT) r_chunk_out <= bus.chunk_in;
         if (r_state == S_REQ && bus.fetch_empty) r_err <= 1'b1;
         if (r_state == S_DONE) begin
            r_idx <= '0;
         end else if (w_handshake && r_idx != LAST_IDX) begin
            r_idx <= r_idx + 1'b1;
         end
      end
   end

   always_comb begin
      bus.fetch_rd_en = 1'b0;
      bus.chunk_valid = 1'b0;
      bus.frame_ack   = 1'b0;
      bus.busy        = 1'b1;
      case (r_state)
         S_IDLE: bus.busy        = 1'b0;
         S_REQ:  bus.fetch_rd_en = ~bus.fetch_empty;
         S_HOLD: bus.chunk_valid = 1'b1;
         S_DONE: bus.frame_ack   = 1'b1;
         default: ;
      endcase
   end

   assign bus.chunk_out  = r_chunk_out;
   assign bus.chunk_idx  = r_idx;
   assign bus.chunk_last = (r_state == S_HOLD) && (r_idx == LAST_IDX);
   assign bus.err        = r_err;
endmodule
